// File: rtl/clock_divider_bank.sv
// clock_divider_bank: multi-channel programmable clock divider.
// Each channel has its own enable, a divisor and a high time. New settings sit in a
// shadow register and are only adopted at a period boundary, while the channel is
// disabled, or on sync. This keeps every period of clock_out whole, with no runt pulses.
module clock_divider_bank #(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = 4_000_000,
  localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic                cfg_ack,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [31:0]      CH_LIMIT = 32'(CHANNELS);

  // Reset asserts asynchronously, but the release is retimed onto clock_in
  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  // Two-flop release synchronizer for the core reset
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_core_n = rst_sync_q[1];

  // The requested settings are clamped once, at write time. This lets the channels
  // assume div >= 2 and high <= div.
  logic [CNT_W-1:0] div_clamp;
  logic [CNT_W-1:0] high_clamp;
  logic             ch_valid;

  assign div_clamp  = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
  assign high_clamp = (cfg_high > div_clamp) ? div_clamp : cfg_high;
  assign ch_valid   = (32'(cfg_ch) < CH_LIMIT);

  logic cfg_ack_q;

  // Every write strobe is acknowledged one cycle later, even when it was dropped
  always_ff @(posedge clock_in or negedge rst_core_n) begin
    if (!rst_core_n) begin
      cfg_ack_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_wr;
    end
  end

  assign cfg_ack = cfg_ack_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] div_a_q, div_a_d;
    logic [CNT_W-1:0] high_a_q, high_a_d;
    logic [CNT_W-1:0] div_s_q, div_s_d;
    logic [CNT_W-1:0] high_s_q, high_s_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic             hold;
    logic             apply;
    logic             wr_hit;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] high_eff;
    logic [CNT_W-1:0] cnt_nxt;

    assign wrap     = (cnt_q >= div_a_q - 1'b1);
    assign hold     = sync || !enable[gi];
    // The shadow may only be adopted where no period is in progress on the output
    assign apply    = pend_q && (hold || wrap);
    assign wr_hit   = cfg_wr && ch_valid && (cfg_ch == CH_W'(gi));
    assign div_eff  = apply ? div_s_q : div_a_q;
    assign high_eff = apply ? high_s_q : high_a_q;
    assign cnt_nxt  = wrap ? '0 : cnt_q + 1'b1;

    // Next-state logic: adopt the shadow, then advance or park the counter,
    // then latch any new write into the shadow.
    always_comb begin
      div_a_d  = div_a_q;
      high_a_d = high_a_q;
      div_s_d  = div_s_q;
      high_s_d = high_s_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      clk_d    = clk_q;
      tick_d   = tick_q;

      if (apply) begin
        div_a_d  = div_s_q;
        high_a_d = high_s_q;
        pend_d   = 1'b0;
      end

      if (hold) begin
        // Parking at div-1 makes the first enabled edge afterwards a wrap
        cnt_d  = div_eff - 1'b1;
        clk_d  = 1'b0;
        tick_d = 1'b0;
      end else begin
        cnt_d  = cnt_nxt;
        clk_d  = (cnt_nxt < high_eff);
        tick_d = wrap;
      end

      // Written after the apply, so a write coinciding with a boundary stays pending
      if (wr_hit) begin
        div_s_d  = div_clamp;
        high_s_d = high_clamp;
        pend_d   = 1'b1;
      end
    end

    // Channel state registers
    always_ff @(posedge clock_in or negedge rst_core_n) begin
      if (!rst_core_n) begin
        div_a_q  <= DEF_DIV;
        high_a_q <= DEF_HIGH;
        div_s_q  <= DEF_DIV;
        high_s_q <= DEF_HIGH;
        pend_q   <= 1'b0;
        cnt_q    <= DEF_DIV - 1'b1;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        div_a_q  <= div_a_d;
        high_a_q <= high_a_d;
        div_s_q  <= div_s_d;
        high_s_q <= high_s_d;
        pend_q   <= pend_d;
        cnt_q    <= cnt_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign clock_out[gi] = clk_q;
    assign tick[gi]      = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: randomized and directed checks of clock_divider_bank.
// The reference model tracks each channel as a position within its current period.
// A channel is "idle" when the next enabled edge starts a new period.
module tb_clock_divider_bank;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] en = '0;
  logic       sy = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] ch = '0;
  logic [7:0] dv = '0;
  logic [7:0] hi = '0;
  logic       ack;
  logic [3:0] cko;
  logic [3:0] tk;

  // The second instance has three channels, so cfg_ch=3 is out of range and must be dropped
  logic [2:0] en3 = '0;
  logic       wr3 = 1'b0;
  logic [1:0] ch3 = 2'd3;
  logic [7:0] dv3 = '0;
  logic [7:0] hi3 = '0;
  logic       ack3;
  logic [2:0] cko3;
  logic [2:0] tk3;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  clock_divider_bank #(.CHANNELS(4), .CNT_W(8), .DEFAULT_DIV(10)) u_dut (
    .clock_in(clk), .reset_n(reset_n), .enable(en), .sync(sy),
    .cfg_wr(wr), .cfg_ch(ch), .cfg_div(dv), .cfg_high(hi),
    .cfg_ack(ack), .clock_out(cko), .tick(tk)
  );

  clock_divider_bank #(.CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(10)) u_dut3 (
    .clock_in(clk), .reset_n(reset_n), .enable(en3), .sync(1'b0),
    .cfg_wr(wr3), .cfg_ch(ch3), .cfg_div(dv3), .cfg_high(hi3),
    .cfg_ack(ack3), .clock_out(cko3), .tick(tk3)
  );

  // Reference model state
  int m_div[4], m_high[4], m_sdiv[4], m_shigh[4], m_pos[4];
  bit m_pend[4], m_idle[4], m_clk[4], m_tick[4];
  bit m_ack;
  int p3;
  bit i3, c3, t3, a3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 10; m_high[i] = 5; m_sdiv[i] = 10; m_shigh[i] = 5;
      m_pend[i] = 0; m_idle[i] = 1; m_pos[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
    m_ack = 0;
    i3 = 1; p3 = 0; c3 = 0; t3 = 0; a3 = 0;
  endtask

  task automatic adopt(input int i);
    if (m_pend[i]) begin
      m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
    end
  endtask

  task automatic model_edge();
    int d, h;
    bit start;
    for (int i = 0; i < 4; i++) begin
      if (sy || !en[i]) begin
        adopt(i);
        m_idle[i] = 1; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        start = m_idle[i] || (m_pos[i] == m_div[i] - 1);
        if (start) begin
          adopt(i);
          m_pos[i] = 0; m_idle[i] = 0;
        end else begin
          m_pos[i]++;
        end
        m_tick[i] = start;
        m_clk[i]  = (m_pos[i] < m_high[i]);
      end
    end
    if (wr) begin
      d = (dv < 2) ? 2 : int'(dv);
      h = (int'(hi) > d) ? d : int'(hi);
      m_sdiv[ch] = d; m_shigh[ch] = h; m_pend[ch] = 1;
    end
    m_ack = wr;
    // Three-channel instance: never reconfigured, so every channel runs at 10/5
    if (en3 != 3'b111) begin
      i3 = 1; c3 = 0; t3 = 0;
    end else begin
      start = i3 || (p3 == 9);
      p3 = start ? 0 : p3 + 1;
      i3 = 0; t3 = start; c3 = (p3 < 5);
    end
    a3 = wr3;
  endtask

  task automatic compare();
    logic [3:0] ec, et;
    for (int i = 0; i < 4; i++) begin
      ec[i] = m_clk[i]; et[i] = m_tick[i];
    end
    check("clock_out", cko, ec);
    check("tick", tk, et);
    check("cfg_ack", ack, m_ack);
    check("clock_out3", cko3, c3 ? 3'b111 : 3'b000);
    check("tick3", tk3, t3 ? 3'b111 : 3'b000);
    check("cfg_ack3", ack3, a3);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_edge();
    @(negedge clk);
    compare();
    sy = 0; wr = 0; wr3 = 0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write(input logic [1:0] c, input logic [7:0] d, input logic [7:0] h);
    wr = 1; ch = c; dv = d; hi = h;
    cycle();
  endtask

  // Holds reset for two edges, releases it, then idles through the release synchronizer
  task automatic reset_seq();
    en = '0; en3 = '0;
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
  endtask

  // Asserts reset between clock edges and checks that the outputs clear immediately
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_clock_out", cko, 4'h0);
    check("rst_tick", tk, 4'h0);
    check("rst_cfg_ack", ack, 1'b0);
    check("rst_clock_out3", cko3, 3'h0);
    model_reset();
    reset_seq();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_seq();
    en3 = 3'b111;

    // Channel 0 from reset: a tick on the first edge, then a 5-high/5-low square wave
    en = 4'b0001;
    cycles(25);

    // Channel 1 is reconfigured mid-period. The current period completes before 7/2 starts.
    en = 4'b0011;
    cycles(2);
    for (int k = 0; k < 40 && m_pos[1] != 3; k++) cycle();
    check("wait_pos1", m_pos[1], 3);
    write(2'd1, 8'd7, 8'd2);
    cycles(24);

    // Clamping: div=1 becomes 2, high=0 is constant low, and high>div is constant high
    write(2'd2, 8'd1, 8'd1);
    write(2'd3, 8'd5, 8'd0);
    en = 4'b1111;
    cycles(20);
    write(2'd2, 8'd8, 8'd20);
    cycles(20);

    // sync realigns all channels; they wrap together on the edge after the pulse
    cycles(3);
    sy = 1;
    cycle();
    cycles(25);

    // Reset in the middle of a high phase
    en = 4'b0001;
    for (int k = 0; k < 40 && !m_clk[0]; k++) cycle();
    check("pre_rst_clk0", cko[0], 1'b1);
    async_reset();
    en3 = 3'b111;
    en = 4'b0001;
    cycles(22);

    // Disable channel 2 mid-period, reconfigure it while idle, then re-enable it
    en = 4'b0100;
    cycles(13);
    en = 4'b0000;
    cycle();
    write(2'd2, 8'd4, 8'd1);
    cycles(3);
    en = 4'b0100;
    wr3 = 1; dv3 = 8'd3; hi3 = 8'd1;
    cycle();
    cycles(12);

    // Randomized traffic, including one reset partway through
    en = 4'b1111;
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        async_reset();
        en3 = 3'b111;
      end
      if ($urandom_range(0, 19) == 0) en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) sy = 1;
      if ($urandom_range(0, 5) == 0) begin
        wr = 1;
        ch = 2'($urandom_range(0, 3));
        dv = 8'($urandom_range(0, 12));
        hi = 8'($urandom_range(0, 14));
      end
      if ($urandom_range(0, 4) == 0) begin
        wr3 = 1;
        dv3 = 8'($urandom);
        hi3 = 8'($urandom);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
